// File: rtl/resnet_stream_ctrl_pkg.sv
// Shared types for the resnet run sequencer: FSM states and stream tags.
// Latency: none (types only).
// Backpressure: none (types only).
package resnet_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Tags which prefetch stream an in-flight memory read belongs to.
    typedef enum logic {
        STR_IN  = 1'b0,
        STR_KER = 1'b1
    } stream_t;

endpackage

// File: rtl/resnet_stream_ctrl_if.sv
// Streaming bus between the run sequencer, the shared memory and the accelerator.
// Latency: memory read data valid one cycle after mem_rd_en; accelerator reads are zero-latency.
// Backpressure: none on the bus; the accelerator pulls words with read strobes.
// Ports: mem_rd_* shared read port, mem_wr_* output write port,
//        acc_in_* / acc_ker_* accelerator pull ports, acc_out_* accelerator push port.
interface resnet_stream_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              acc_in_read_en;
    logic [DATA_W-1:0] acc_in_data;
    logic              acc_ker_read_en;
    logic [DATA_W-1:0] acc_ker_data;
    logic              acc_out_valid;
    logic [DATA_W-1:0] acc_out_data;

    // Controller side.
    modport master (
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output acc_in_data, acc_ker_data,
        input  mem_rd_data, acc_in_read_en, acc_ker_read_en, acc_out_valid, acc_out_data
    );

    // Memory / accelerator side.
    modport slave (
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  acc_in_data, acc_ker_data,
        output mem_rd_data, acc_in_read_en, acc_ker_read_en, acc_out_valid, acc_out_data
    );

endinterface

// File: rtl/resnet_stream_ctrl_prefetch_fifo.sv
// Small prefetch FIFO for one stream; head is shown combinationally (0 when empty).
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: pushes to a full FIFO are dropped unless a pop frees a slot in the same cycle.
// Ports: clk/rst, clr_i (synchronous empty), push_i/push_dat_i, pop_i, head_o, count_o.
module stream_prefetch_fifo #(
    parameter int DATA_W   = 16,
    parameter int PF_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr_i,
    input  logic                           push_i,
    input  logic [DATA_W-1:0]              push_dat_i,
    input  logic                           pop_i,
    output logic [DATA_W-1:0]              head_o,
    output logic [$clog2(PF_DEPTH+1)-1:0]  count_o
);
    localparam int PW = $clog2(PF_DEPTH);
    localparam int CW = $clog2(PF_DEPTH+1);

    logic [DATA_W-1:0] mem_q [PF_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(PF_DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    // Storage carries no reset; only words covered by count_q are ever shown.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/resnet_stream_ctrl.sv
// Run sequencer: flush pulse, input/kernel prefetch from one shared read port, output write-back.
// Latency: accelerator reads zero-latency from FIFO heads; refill read returns one cycle after grant.
// Backpressure: prefetch stalls when occupancy+inflight reaches PF_DEPTH; empty reads flag err_underrun.
// Ports: clk, rst (async, active high), start_i, busy_o, done_o, err_underrun_o, err_overread_o,
//        flush_o, strm (memory and accelerator bus, master side).
module resnet_stream_ctrl
    import resnet_ctrl_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int IN_WORDS     = 7200,
    parameter int KER_WORDS    = 216,
    parameter int OUT_WORDS    = 1024,
    parameter int IN_BASE      = 0,
    parameter int KER_BASE     = 7200,
    parameter int OUT_BASE     = 8192,
    parameter int PF_DEPTH     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    output logic err_underrun_o,
    output logic err_overread_o,
    output logic flush_o,
    resnet_stream_ctrl_if.master strm
);
    localparam int IC_W = $clog2(IN_WORDS+1);
    localparam int KC_W = $clog2(KER_WORDS+1);
    localparam int OC_W = $clog2(OUT_WORDS+1);
    localparam int FC_W = $clog2(FLUSH_CYCLES+1);
    localparam int CW   = $clog2(PF_DEPTH+1);

    state_t          state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q;
    logic [IC_W-1:0] in_issued_q, in_deliv_q;
    logic [KC_W-1:0] ker_issued_q, ker_deliv_q;
    logic [OC_W-1:0] out_cnt_q;
    logic            prio_ker_q;   // kernel wins the next tie
    logic            rd_vld_q;
    stream_t         rd_tag_q;
    logic            err_underrun_q, err_overread_q;

    logic            run_start, prefetch_on, in_run;
    logic [CW-1:0]   in_cnt, ker_cnt;
    logic            in_infl, ker_infl, in_elig, ker_elig, gnt_in, gnt_ker;
    logic            in_over, in_under, in_pop, ker_over, ker_under, ker_pop;
    logic            wr_fire;

    assign run_start   = (state_q == IDLE) && start_i;
    assign prefetch_on = (state_q == FLUSH) || (state_q == RUN);
    assign in_run      = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        done_o  = (state_q == DONE);
        flush_o = (state_q == FLUSH);
        unique case (state_q)
            IDLE:    if (start_i) state_d = FLUSH;
            FLUSH:   if (flush_cnt_q == FC_W'(FLUSH_CYCLES-1)) state_d = RUN;
            RUN:     if (out_cnt_q == OC_W'(OUT_WORDS)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A stream may refill only while words remain and the FIFO has room for
    // everything already requested, including the read still returning.
    assign in_infl  = rd_vld_q && (rd_tag_q == STR_IN);
    assign ker_infl = rd_vld_q && (rd_tag_q == STR_KER);
    assign in_elig  = prefetch_on && (in_issued_q < IC_W'(IN_WORDS)) &&
                      (((CW+1)'(in_cnt) + (CW+1)'(in_infl)) < (CW+1)'(PF_DEPTH));
    assign ker_elig = prefetch_on && (ker_issued_q < KC_W'(KER_WORDS)) &&
                      (((CW+1)'(ker_cnt) + (CW+1)'(ker_infl)) < (CW+1)'(PF_DEPTH));
    assign gnt_in   = in_elig && (!ker_elig || !prio_ker_q);
    assign gnt_ker  = ker_elig && (!in_elig || prio_ker_q);

    assign strm.mem_rd_en   = gnt_in || gnt_ker;
    assign strm.mem_rd_addr = gnt_ker ? (ADDR_W'(KER_BASE) + ADDR_W'(ker_issued_q)) :
                              gnt_in  ? (ADDR_W'(IN_BASE)  + ADDR_W'(in_issued_q))  : '0;

    // Overread takes precedence: once every word is delivered the FIFO is
    // necessarily empty, and that case is reported as overread, not underrun.
    assign in_over   = in_run && strm.acc_in_read_en && (in_deliv_q == IC_W'(IN_WORDS));
    assign in_under  = in_run && strm.acc_in_read_en && !in_over && (in_cnt == '0);
    assign in_pop    = in_run && strm.acc_in_read_en && !in_over && (in_cnt != '0);
    assign ker_over  = in_run && strm.acc_ker_read_en && (ker_deliv_q == KC_W'(KER_WORDS));
    assign ker_under = in_run && strm.acc_ker_read_en && !ker_over && (ker_cnt == '0);
    assign ker_pop   = in_run && strm.acc_ker_read_en && !ker_over && (ker_cnt != '0);

    assign wr_fire          = in_run && strm.acc_out_valid && (out_cnt_q != OC_W'(OUT_WORDS));
    assign strm.mem_wr_en   = wr_fire;
    assign strm.mem_wr_addr = wr_fire ? (ADDR_W'(OUT_BASE) + ADDR_W'(out_cnt_q)) : '0;
    assign strm.mem_wr_data = wr_fire ? strm.acc_out_data : '0;

    assign err_underrun_o = err_underrun_q;
    assign err_overread_o = err_overread_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            flush_cnt_q    <= '0;
            in_issued_q    <= '0;
            in_deliv_q     <= '0;
            ker_issued_q   <= '0;
            ker_deliv_q    <= '0;
            out_cnt_q      <= '0;
            prio_ker_q     <= 1'b0;
            rd_vld_q       <= 1'b0;
            rd_tag_q       <= STR_IN;
            err_underrun_q <= 1'b0;
            err_overread_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + FC_W'(1) : '0;
            rd_vld_q    <= gnt_in || gnt_ker;
            rd_tag_q    <= gnt_ker ? STR_KER : STR_IN;
            // Priority moves away from whichever stream just won.
            if (gnt_in || gnt_ker) prio_ker_q <= gnt_in;
            if (run_start) begin
                in_issued_q    <= '0;
                in_deliv_q     <= '0;
                ker_issued_q   <= '0;
                ker_deliv_q    <= '0;
                out_cnt_q      <= '0;
                err_underrun_q <= 1'b0;
                err_overread_q <= 1'b0;
            end else begin
                if (gnt_in)  in_issued_q  <= in_issued_q + IC_W'(1);
                if (gnt_ker) ker_issued_q <= ker_issued_q + KC_W'(1);
                if (in_pop)  in_deliv_q   <= in_deliv_q + IC_W'(1);
                if (ker_pop) ker_deliv_q  <= ker_deliv_q + KC_W'(1);
                if (wr_fire) out_cnt_q    <= out_cnt_q + OC_W'(1);
                if (in_under || ker_under) err_underrun_q <= 1'b1;
                if (in_over || ker_over)   err_overread_q <= 1'b1;
            end
        end
    end

    stream_prefetch_fifo #(.DATA_W(DATA_W), .PF_DEPTH(PF_DEPTH)) u_in_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (run_start),
        .push_i     (rd_vld_q && (rd_tag_q == STR_IN)),
        .push_dat_i (strm.mem_rd_data),
        .pop_i      (in_pop),
        .head_o     (strm.acc_in_data),
        .count_o    (in_cnt)
    );

    stream_prefetch_fifo #(.DATA_W(DATA_W), .PF_DEPTH(PF_DEPTH)) u_ker_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (run_start),
        .push_i     (rd_vld_q && (rd_tag_q == STR_KER)),
        .push_dat_i (strm.mem_rd_data),
        .pop_i      (ker_pop),
        .head_o     (strm.acc_ker_data),
        .count_o    (ker_cnt)
    );

endmodule

// File: tb/tb_resnet_stream_ctrl.sv
// Directed bench for resnet_stream_ctrl with a small run (8 input, 4 kernel, 3 output words).
// Latency: memory model returns data = address one cycle after each read request.
// Backpressure: accelerator read and output strobes are driven directly by the stimulus.
module tb_resnet_stream_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, err_underrun, err_overread, flush;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int nfl;
    logic found;
    logic [15:0] rd_log[$];
    logic [31:0] wr_log[$];
    logic [15:0] got[8];

    always #5 clk = ~clk;

    resnet_stream_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    resnet_stream_ctrl #(
        .DATA_W(16), .ADDR_W(16), .IN_WORDS(8), .KER_WORDS(4), .OUT_WORDS(3),
        .IN_BASE(0), .KER_BASE(100), .OUT_BASE(200), .PF_DEPTH(4), .FLUSH_CYCLES(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .busy_o         (busy),
        .done_o         (done),
        .err_underrun_o (err_underrun),
        .err_overread_o (err_overread),
        .flush_o        (flush),
        .strm           (bus)
    );

    // Shared memory: every location holds its own address.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_rd_addr;
    end

    always @(negedge clk) begin
        if (bus.mem_rd_en) rd_log.push_back(bus.mem_rd_addr);
        if (bus.mem_wr_en) wr_log.push_back({bus.mem_wr_addr, bus.mem_wr_data});
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_rd[8];
        exp_rd = '{16'd0, 16'd100, 16'd1, 16'd101, 16'd2, 16'd102, 16'd3, 16'd103};
        bus.mem_rd_data     = '0;
        bus.acc_in_read_en  = 1'b0;
        bus.acc_ker_read_en = 1'b0;
        bus.acc_out_valid   = 1'b0;
        bus.acc_out_data    = '0;
        repeat (2) step();

        // Reset state
        check("rst_busy",   32'(busy), 0);
        check("rst_done",   32'(done), 0);
        check("rst_flush",  32'(flush), 0);
        check("rst_errs",   32'({err_underrun, err_overread}), 0);
        check("rst_rd_en",  32'(bus.mem_rd_en), 0);
        check("rst_wr_en",  32'(bus.mem_wr_en), 0);
        check("rst_in_dat", 32'(bus.acc_in_data), 0);
        rst = 1'b0;
        step();

        // Run 1: flush length, prefill order, back-to-back input pull
        rd_log.delete();
        wr_log.delete();
        start = 1'b1; step(); start = 1'b0;
        check("r1_busy", 32'(busy), 1);
        nfl = 0;
        for (int i = 0; i < 6; i++) begin
            nfl += int'(flush);
            step();
        end
        check("r1_flush_len", 32'(nfl), 2);
        repeat (8) step();
        check("r1_prefill_cnt", 32'(rd_log.size()), 8);
        for (int i = 0; i < 8; i++)
            check("r1_prefill_addr", 32'((i < rd_log.size()) ? rd_log[i] : 16'hdead), 32'(exp_rd[i]));
        check("r1_in_head",  32'(bus.acc_in_data), 0);
        check("r1_ker_head", 32'(bus.acc_ker_data), 100);

        bus.acc_in_read_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            got[i] = bus.acc_in_data;
            step();
        end
        bus.acc_in_read_en = 1'b0;
        for (int i = 0; i < 8; i++) check("r1_in_seq", 32'(got[i]), 32'(i));
        check("r1_no_underrun", 32'(err_underrun), 0);

        for (int i = 0; i < 4; i++) begin
            bus.acc_ker_read_en = 1'b1;
            got[i] = bus.acc_ker_data;
            step();
            bus.acc_ker_read_en = 1'b0;
            step();
        end
        for (int i = 0; i < 4; i++) check("r1_ker_seq", 32'(got[i]), 32'(100 + i));

        for (int i = 0; i < 3; i++) begin
            bus.acc_out_valid = 1'b1;
            bus.acc_out_data  = 16'(16'hA + i);
            step();
            bus.acc_out_valid = 1'b0;
            step();
        end
        repeat (6) step();
        check("r1_wr_cnt", 32'(wr_log.size()), 3);
        for (int i = 0; i < 3; i++)
            check("r1_wr", (i < wr_log.size()) ? wr_log[i] : 32'hdeadbeef,
                  {16'(200 + i), 16'(16'hA + i)});
        check("r1_done_cnt", 32'(done_cnt), 1);
        check("r1_idle", 32'(busy), 0);
        check("r1_errs", 32'({err_underrun, err_overread}), 0);

        // Run 2: underrun in first RUN cycle, then kernel overread
        rst = 1'b1; step(); rst = 1'b0; step();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10 && flush; i++) step();
        check("r2_in_run", 32'({busy, flush}), 32'b10);
        bus.acc_ker_read_en = 1'b1; step(); bus.acc_ker_read_en = 1'b0;
        check("r2_underrun", 32'(err_underrun), 1);
        check("r2_no_overread", 32'(err_overread), 0);
        check("r2_ker_not_popped", 32'(bus.acc_ker_data), 100);
        repeat (10) step();
        bus.acc_ker_read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got[i] = bus.acc_ker_data;
            step();
        end
        check("r2_ker_last", 32'(got[3]), 103);
        check("r2_overread_pre", 32'(err_overread), 0);
        step();
        bus.acc_ker_read_en = 1'b0;
        check("r2_overread", 32'(err_overread), 1);
        bus.acc_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.acc_out_data = 16'(i + 1);
            step();
        end
        bus.acc_out_valid = 1'b0;
        repeat (6) step();
        check("r2_done_cnt", 32'(done_cnt), 2);

        // Run 3: start clears errors; reset while a kernel read is in flight
        start = 1'b1; step(); start = 1'b0;
        check("r3_errs_clr", 32'({err_underrun, err_overread}), 0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_rd_en && bus.mem_rd_addr == 16'd100) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("r3_ker_grant", 32'(found), 1);
        step();
        rst = 1'b1; #1;
        check("r3_rst_outs", 32'({busy, flush, done, bus.mem_rd_en, bus.mem_wr_en}), 0);
        check("r3_rst_in_dat", 32'(bus.acc_in_data), 0);
        #2 rst = 1'b0;
        step();
        check("r3_late_discard", 32'(bus.acc_ker_data), 0);
        check("r3_idle", 32'(busy), 0);

        // Run 4: replay from base, valid in FLUSH and start in RUN ignored
        rd_log.delete();
        wr_log.delete();
        start = 1'b1; step(); start = 1'b0;
        bus.acc_out_valid = 1'b1;
        bus.acc_out_data  = 16'h55;
        start = 1'b1;
        #1;
        check("r4_wr_in_flush", 32'(bus.mem_wr_en), 0);
        nfl = int'(flush);
        step();
        bus.acc_out_valid = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nfl += int'(flush);
            step();
        end
        check("r4_flush_len", 32'(nfl), 2);
        check("r4_replay_in",  32'((rd_log.size() > 0) ? rd_log[0] : 16'hdead), 0);
        check("r4_replay_ker", 32'((rd_log.size() > 1) ? rd_log[1] : 16'hdead), 100);
        start = 1'b1; step(); start = 1'b0;
        check("r4_start_ignored", 32'({busy, flush}), 32'b10);
        bus.acc_out_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.acc_out_data = 16'(i + 1);
            step();
        end
        bus.acc_out_valid = 1'b0;
        repeat (4) step();
        check("r4_wr_cnt", 32'(wr_log.size()), 3);
        for (int i = 0; i < 3; i++)
            check("r4_wr", (i < wr_log.size()) ? wr_log[i] : 32'hdeadbeef,
                  {16'(200 + i), 16'(i + 1)});
        check("r4_done_cnt", 32'(done_cnt), 3);
        check("r4_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
